// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader: encodes descriptor stream into 32-bit words, loads IMEM
// Optional INSTR_LOADER_CHECKSUM_EN adds an XOR checksum output.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
`ifdef INSTR_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                start_load;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_wdata_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     word_count_q;
  logic                err_q;
  logic [31:0]         w_word;
  logic                w_xfer, w_legal, w_xfer_ok, w_ovf;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [ADDR_W:0]     w_cnt_after;

  assign in_ready  = (state_q == S_LOAD);
  assign w_xfer    = in_valid & in_ready;
  assign w_legal   = (in_kind <= 3'd4);
  assign w_xfer_ok = w_xfer & w_legal;

  // Address and count commit one edge after acceptance, so a write still in
  // flight has to be folded in when a back-to-back descriptor arrives.
  assign w_wr_addr   = addr_q + ADDR_W'(mem_we_q);
  assign w_cnt_after = word_count_q + (ADDR_W+1)'(mem_we_q) + (ADDR_W+1)'(1);
  assign w_ovf       = w_xfer_ok & ~in_last & (w_cnt_after == DEPTH_C);

  always_comb begin
    w_word = 32'h0;
    case (in_kind)
      3'd0:                w_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, in_funct};
      3'd1, 3'd2, 3'd3:    w_word = {3'b000, in_kind, in_rs, in_rt, in_imm};
      3'd4:                w_word = {6'b000100, in_target};
      default:             w_word = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    start_load = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_LOAD;
          start_load = 1'b1;
        end
      end
      S_LOAD: begin
        if (w_xfer && (!w_legal || in_last || w_ovf)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
      addr_q       <= BASE_C;
      word_count_q <= '0;
      err_q        <= 1'b0;
    end else begin
      mem_we_q <= w_xfer_ok;
      if (w_xfer_ok) begin
        mem_addr_q  <= w_wr_addr;
        mem_wdata_q <= w_word;
      end
      if (start_load) begin
        addr_q       <= BASE_C;
        word_count_q <= '0;
        err_q        <= 1'b0;
      end else begin
        if (mem_we_q) begin
          addr_q       <= addr_q + ADDR_W'(1);
          word_count_q <= word_count_q + (ADDR_W+1)'(1);
        end
        if (w_xfer && (!w_legal || w_ovf)) err_q <= 1'b1;
      end
    end
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [31:0] checksum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          checksum_q <= 32'h0;
    else if (start_load) checksum_q <= 32'h0;
    else if (mem_we_q)   checksum_q <= checksum_q ^ mem_wdata_q;
  end

  assign checksum = checksum_q;
`endif

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = (state_q == S_LOAD);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign word_count = word_count_q;

endmodule

`default_nettype wire
